reg_wb_scheduler: RTL and testbench
===================================

# reg_wb_scheduler

Write-back scheduler and scoreboard for the CPU's 32 x 32-bit register file, which has a single write port.
- Merges three write-back sources onto that port: the single-cycle ALU, the load unit and the multiply/divide unit.
- Tracks registers with an outstanding long-latency write.
- Stalls issue on RAW/WAW hazards and on write-back starvation.
- Sits between the issue stage, the execution units and the register file write port.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive cycles a long source may wait un-granted before issue is forced to stall (1..15)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  issue stage presents an instruction
- issue_rs1  in  5  source register 1
- issue_rs2  in  5  source register 2
- issue_rd  in  5  destination register
- issue_long  in  1  instruction writes rd via the load or mul/div unit
- issue_stall  out  1  instruction must not issue this cycle
- alu_wb_valid  in  1  ALU write-back present; always accepted
- alu_wb_addr  in  5  ALU destination
- alu_wb_data  in  32  ALU result
- ld_wb_valid, ld_wb_addr[4:0], ld_wb_data[31:0]  in  load write-back request
- ld_wb_ready  out  1  load write-back accepted this cycle
- md_wb_valid, md_wb_addr[4:0], md_wb_data[31:0]  in  mul/div write-back request
- md_wb_ready  out  1  mul/div write-back accepted this cycle
- rf_write_en  out  1  register file write enable
- rf_wr_addr  out  5  register file write address
- rf_wr_data  out  32  register file write data
- busy_mask  out  32  registered scoreboard; bit n = register n has a pending long write
- wb_error  out  1  sticky: long write-back arrived for a register that was not busy

## Operation
Arbitration (combinational):
- alu_wb_valid=1: ALU is granted; ld_wb_ready=md_wb_ready=0.
- Otherwise, if both long sources are valid, round-robin picks the one not granted last; if only one is valid, it is granted.
- The round-robin pointer updates only on a long-source grant.
- Grant drives rf_wr_addr/rf_wr_data from the winner. rf_write_en=1 iff a grant exists and its addr≠0.
- Address-0 write-backs still complete their handshake.
- When no grant: rf_write_en=0, rf_wr_addr=0, rf_wr_data=0.
- The ready outputs depend on valids. Source valid must not depend on ready.
- A source holds valid/addr/data stable until accepted.

Scoreboard:
- busy[0] is always 0.
- Clear: a long grant to addr a clears busy[a].
- Set: issue fire (issue_valid & !issue_stall) with issue_long=1 and issue_rd≠0 sets busy[issue_rd].
- Set wins over clear when both hit the same register in the same cycle.
- A long grant to a non-busy, nonzero addr sets wb_error (sticky until reset). The data is still written.

Hazard stall:
- Effective busy for a register = busy[n] & !(long grant clearing n this cycle). The register file forwards its write data, so the clearing cycle itself needs no stall.
- issue_stall = issue_valid & (eff_busy[rs1] | eff_busy[rs2] | eff_busy[rd] | starve).
- The rd check applies to all instructions (WAW).

Starvation counter (4-bit):
- Increments, saturating at STARVE_LIMIT, each cycle (ld_wb_valid | md_wb_valid) with no long grant.
- Clears to 0 on any long grant or when neither long source is valid.
- starve = (count == STARVE_LIMIT). It holds issue stalled until the ALU drains and a long source is granted.

Reset:
- busy_mask=0, wb_error=0, counter=0, round-robin favours load first.
- While reset is high: rf_write_en=0, both ready=0, issue_stall=1.
- Reset mid-operation discards all pending busy state. Flushing the long units is external.

## Timing
- Write-back grant to register file write: 0 cycles (same cycle). Data is architecturally visible at the next edge; same-cycle readers get it through register-file forwarding.
- Issue fire to busy bit set: visible in busy_mask and the stall logic from the next cycle.
- Grant to busy bit clear: affects stall in the same cycle; busy_mask updates at the next edge.
- The starvation stall asserts in the cycle the counter reaches STARVE_LIMIT, which is STARVE_LIMIT cycles after the wait begins.
- Only combinational paths: issue inputs / wb valids → issue_stall, readies, rf_* outputs.

## Test plan
- Reset, then issue long rd=5, then ALU reads rs1=5 → stall=1; ld write-back addr 5, data 0xDEADBEEF → same cycle rf_write_en=1, addr 5, stall=0; next cycle busy_mask[5]=0.
- ld and md both valid (addr 3 / addr 4), no ALU → ld granted first, then md; on a second simultaneous request ld is granted again; a write-back is never dropped.
- alu_wb_valid held high for 6 cycles with ld_wb_valid pending, STARVE_LIMIT=4 → ld_wb_ready=0 throughout; issue_stall=1 from cycle 4; ld granted in the first ALU-free cycle; counter returns to 0.
- Issue long rd=0 → busy_mask stays 0; md write-back addr 0 → md_wb_ready=1, rf_write_en=0, wb_error=0.
- Same cycle: ld grant clears r7 and a new long issue targets rd=7 → no stall; busy[7]=1 next cycle.
- Pending busy r9, assert reset for one cycle → busy_mask=0 and issue_stall=0 after reset; a later ld write-back to r9 sets wb_error=1.

Source files
------------

// File: rtl/reg_wb_scheduler.sv
// Write-back arbiter and long-latency scoreboard for the 32x32 single-write-port register file.
// Grant and write are in the same cycle; loads and mul/div wait on ready while the ALU has the port, and issue stalls on hazards or starvation.
module reg_wb_scheduler #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_rs1,
  input  logic [4:0]  i_issue_rs2,
  input  logic [4:0]  i_issue_rd,
  input  logic        i_issue_long,
  output logic        o_issue_stall,
  input  logic        i_alu_wb_valid,
  input  logic [4:0]  i_alu_wb_addr,
  input  logic [31:0] i_alu_wb_data,
  input  logic        i_ld_wb_valid,
  input  logic [4:0]  i_ld_wb_addr,
  input  logic [31:0] i_ld_wb_data,
  output logic        o_ld_wb_ready,
  input  logic        i_md_wb_valid,
  input  logic [4:0]  i_md_wb_addr,
  input  logic [31:0] i_md_wb_data,
  output logic        o_md_wb_ready,
  output logic        o_rf_write_en,
  output logic [4:0]  o_rf_wr_addr,
  output logic [31:0] o_rf_wr_data,
  output logic [31:0] o_busy_mask,
  output logic        o_wb_error
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [31:0] r_busy;
  logic        r_wb_error;
  logic [3:0]  r_starve_cnt;
  logic        r_rr_md;

  logic        w_alu_gnt;
  logic        w_ld_gnt;
  logic        w_md_gnt;
  logic        w_long_gnt;
  logic [4:0]  w_long_addr;
  logic [31:0] w_clr_mask;
  logic [31:0] w_set_mask;
  logic [31:0] w_eff_busy;
  logic        w_starve;
  logic        w_fire;

  // r_rr_md set means load won last, so mul/div gets the next tie
  always_comb begin
    w_alu_gnt   = !i_reset && i_alu_wb_valid;
    w_ld_gnt    = !i_reset && !i_alu_wb_valid && i_ld_wb_valid &&
                  (!i_md_wb_valid || !r_rr_md);
    w_md_gnt    = !i_reset && !i_alu_wb_valid && i_md_wb_valid &&
                  (!i_ld_wb_valid || r_rr_md);
    w_long_gnt  = w_ld_gnt || w_md_gnt;
    w_long_addr = w_md_gnt ? i_md_wb_addr : i_ld_wb_addr;
  end

  always_comb begin
    o_rf_wr_addr = '0;
    o_rf_wr_data = '0;
    if (w_alu_gnt) begin
      o_rf_wr_addr = i_alu_wb_addr;
      o_rf_wr_data = i_alu_wb_data;
    end else if (w_ld_gnt) begin
      o_rf_wr_addr = i_ld_wb_addr;
      o_rf_wr_data = i_ld_wb_data;
    end else if (w_md_gnt) begin
      o_rf_wr_addr = i_md_wb_addr;
      o_rf_wr_data = i_md_wb_data;
    end
  end

  assign o_rf_write_en = (w_alu_gnt || w_long_gnt) && (o_rf_wr_addr != 5'd0);
  assign o_ld_wb_ready = w_ld_gnt;
  assign o_md_wb_ready = w_md_gnt;

  // A register cleared this cycle is readable via register-file forwarding
  always_comb begin
    w_clr_mask    = w_long_gnt ? (32'd1 << w_long_addr) : 32'd0;
    w_eff_busy    = r_busy & ~w_clr_mask;
    w_starve      = (r_starve_cnt == LIM);
    o_issue_stall = i_reset || (i_issue_valid &&
                    (w_eff_busy[i_issue_rs1] || w_eff_busy[i_issue_rs2] ||
                     w_eff_busy[i_issue_rd]  || w_starve));
    w_fire        = i_issue_valid && !o_issue_stall;
    w_set_mask    = (w_fire && i_issue_long && (i_issue_rd != 5'd0)) ?
                    (32'd1 << i_issue_rd) : 32'd0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy       <= '0;
      r_wb_error   <= 1'b0;
      r_starve_cnt <= '0;
      r_rr_md      <= 1'b0;
    end else begin
      r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
      if (w_long_gnt && (w_long_addr != 5'd0) && !r_busy[w_long_addr])
        r_wb_error <= 1'b1;
      if (w_ld_gnt)
        r_rr_md <= 1'b1;
      else if (w_md_gnt)
        r_rr_md <= 1'b0;
      if (w_long_gnt || !(i_ld_wb_valid || i_md_wb_valid))
        r_starve_cnt <= '0;
      else if (r_starve_cnt != LIM)
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  assign o_busy_mask = r_busy;
  assign o_wb_error  = r_wb_error;

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Directed bench for reg_wb_scheduler: drives after the rising edge, samples mid-cycle.
module tb_reg_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_long, issue_stall;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        alu_v, ld_v, md_v, ld_rdy, md_rdy;
  logic [4:0]  alu_a, ld_a, md_a;
  logic [31:0] alu_d, ld_d, md_d;
  logic        rf_we;
  logic [4:0]  rf_a;
  logic [31:0] rf_d;
  logic [31:0] busy_mask;
  logic        wb_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_wb_scheduler #(.STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_issue_valid(issue_valid), .i_issue_rs1(issue_rs1), .i_issue_rs2(issue_rs2),
    .i_issue_rd(issue_rd), .i_issue_long(issue_long), .o_issue_stall(issue_stall),
    .i_alu_wb_valid(alu_v), .i_alu_wb_addr(alu_a), .i_alu_wb_data(alu_d),
    .i_ld_wb_valid(ld_v), .i_ld_wb_addr(ld_a), .i_ld_wb_data(ld_d), .o_ld_wb_ready(ld_rdy),
    .i_md_wb_valid(md_v), .i_md_wb_addr(md_a), .i_md_wb_data(md_d), .o_md_wb_ready(md_rdy),
    .o_rf_write_en(rf_we), .o_rf_wr_addr(rf_a), .o_rf_wr_data(rf_d),
    .o_busy_mask(busy_mask), .o_wb_error(wb_error)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    issue_valid = 0; issue_long = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    alu_v = 0; alu_a = 0; alu_d = 0;
    ld_v = 0; ld_a = 0; ld_d = 0;
    md_v = 0; md_a = 0; md_d = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic lng);
    issue_valid = 1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_long = lng;
  endtask

  initial begin
    idle();
    reset = 1;
    // outputs forced quiet during reset even with requests present
    alu_v = 1; alu_a = 5'd2; alu_d = 32'h1; ld_v = 1; ld_a = 5'd3;
    settle();
    check_val("rst_rf_we", rf_we, 0);
    check_val("rst_ld_rdy", ld_rdy, 0);
    check_val("rst_stall", issue_stall, 1);
    next_cyc();
    next_cyc();
    idle();
    reset = 0;
    settle();
    check_val("rst_busy", busy_mask, 0);
    check_val("rst_err", wb_error, 0);
    check_val("rst_stall_off", issue_stall, 0);

    // round-robin between load and mul/div
    issue(0, 0, 5'd3, 1); next_cyc();
    issue(0, 0, 5'd4, 1); next_cyc();
    idle();
    settle();
    check_val("rr_busy", busy_mask, 32'h18);
    ld_v = 1; ld_a = 5'd3; ld_d = 32'h33; md_v = 1; md_a = 5'd4; md_d = 32'h44;
    settle();
    check_val("rr1_ld_rdy", ld_rdy, 1);
    check_val("rr1_md_rdy", md_rdy, 0);
    check_val("rr1_addr", rf_a, 3);
    check_val("rr1_data", rf_d, 32'h33);
    next_cyc();
    ld_v = 0;
    settle();
    check_val("rr2_md_rdy", md_rdy, 1);
    check_val("rr2_addr", rf_a, 4);
    check_val("rr2_data", rf_d, 32'h44);
    next_cyc();
    idle();
    issue(0, 0, 5'd3, 1); next_cyc();
    issue(0, 0, 5'd4, 1); next_cyc();
    idle();
    ld_v = 1; ld_a = 5'd3; ld_d = 32'h333; md_v = 1; md_a = 5'd4; md_d = 32'h444;
    settle();
    check_val("rr3_ld_rdy", ld_rdy, 1);
    check_val("rr3_md_rdy", md_rdy, 0);
    next_cyc();
    ld_v = 0;
    settle();
    check_val("rr4_md_rdy", md_rdy, 1);
    next_cyc();
    idle();
    settle();
    check_val("rr_busy_end", busy_mask, 0);
    check_val("rr_err", wb_error, 0);

    // RAW on a pending load, cleared by same-cycle write-back
    issue(5'd1, 5'd2, 5'd5, 1);
    settle();
    check_val("raw_issue", issue_stall, 0);
    next_cyc();
    issue(5'd5, 5'd0, 5'd6, 0);
    settle();
    check_val("raw_busy", busy_mask, 32'h20);
    check_val("raw_stall", issue_stall, 1);
    ld_v = 1; ld_a = 5'd5; ld_d = 32'hDEADBEEF;
    settle();
    check_val("raw_we", rf_we, 1);
    check_val("raw_addr", rf_a, 5);
    check_val("raw_data", rf_d, 32'hDEADBEEF);
    check_val("raw_nostall", issue_stall, 0);
    next_cyc();
    idle();
    settle();
    check_val("raw_clear", busy_mask, 0);

    // starvation: ALU hogs the port for 6 cycles
    issue(0, 0, 5'd10, 1); next_cyc();
    idle();
    for (int k = 0; k < 6; k++) begin
      issue(0, 0, 0, 0);
      alu_v = 1; alu_a = 5'd1; alu_d = 32'(k);
      ld_v = 1; ld_a = 5'd10; ld_d = 32'hA5A5;
      settle();
      check_val($sformatf("stv_ld_rdy%0d", k), ld_rdy, 0);
      check_val($sformatf("stv_stall%0d", k), issue_stall, (k >= 4) ? 1 : 0);
      next_cyc();
    end
    alu_v = 0;
    settle();
    check_val("stv_grant", ld_rdy, 1);
    check_val("stv_addr", rf_a, 10);
    check_val("stv_hold", issue_stall, 1);
    next_cyc();
    ld_v = 0;
    settle();
    check_val("stv_release", issue_stall, 0);
    check_val("stv_busy", busy_mask, 0);
    idle();
    next_cyc();

    // register 0 never goes busy and is never written
    issue(0, 0, 0, 1); next_cyc();
    idle();
    settle();
    check_val("r0_busy", busy_mask, 0);
    md_v = 1; md_a = 0; md_d = 32'h55;
    settle();
    check_val("r0_md_rdy", md_rdy, 1);
    check_val("r0_we", rf_we, 0);
    next_cyc();
    idle();
    settle();
    check_val("r0_err", wb_error, 0);

    // clear and set of r7 in the same cycle: set wins
    issue(0, 0, 5'd7, 1); next_cyc();
    issue(0, 0, 5'd7, 1);
    ld_v = 1; ld_a = 5'd7; ld_d = 32'h77;
    settle();
    check_val("sc_stall", issue_stall, 0);
    check_val("sc_ld_rdy", ld_rdy, 1);
    next_cyc();
    idle();
    settle();
    check_val("sc_busy", busy_mask, 32'h80);
    check_val("sc_err", wb_error, 0);

    // reset discards pending busy state
    issue(0, 0, 5'd9, 1); next_cyc();
    idle();
    settle();
    check_val("mr_busy", busy_mask, 32'h280);
    reset = 1;
    settle();
    check_val("mr_stall", issue_stall, 1);
    next_cyc();
    reset = 0;
    issue(5'd9, 0, 0, 0);
    settle();
    check_val("mr_cleared", busy_mask, 0);
    check_val("mr_nostall", issue_stall, 0);
    next_cyc();
    idle();
    ld_v = 1; ld_a = 5'd9; ld_d = 32'h99;
    settle();
    check_val("mr_ld_rdy", ld_rdy, 1);
    next_cyc();
    idle();
    settle();
    check_val("mr_err", wb_error, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
